// File: rtl/iter_layer_engine_pkg.sv
// Shared sizing, Tanner-graph edge map, FSM encoding and arithmetic helpers
// for the iterative min-sum layer engine.
package iter_layer_engine_pkg;

  localparam int WIDTH         = 6;
  localparam int N_V           = 4;
  localparam int E             = 6;
  localparam int EXTENDED_BITS = 2;
  localparam int MAX_ITER      = 8;
  localparam int INT_SIZE      = 4;
  localparam int CNT_W         = INT_SIZE;
  localparam int ACC_W         = WIDTH + EXTENDED_BITS;
  localparam int MAX_MAG       = 2**(WIDTH-1) - 1;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(MAX_MAG);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI;

  // Edge e joins variable EDGE_VAR[e] and check EDGE_CHK[e]; H rows are 1110 and 0111.
  localparam int EDGE_VAR [E] = '{0, 1, 2, 1, 2, 3};
  localparam int EDGE_CHK [E] = '{0, 0, 0, 1, 1, 1};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  // Offset applied to check-node magnitudes; tapers as passes progress.
  function automatic logic [WIDTH-2:0] lut_bias(input logic [INT_SIZE-1:0] idx);
    logic [WIDTH-2:0] b;
    case (idx)
      INT_SIZE'(0), INT_SIZE'(1): b = (WIDTH-1)'(3);
      INT_SIZE'(2), INT_SIZE'(3): b = (WIDTH-1)'(2);
      INT_SIZE'(4), INT_SIZE'(5): b = (WIDTH-1)'(1);
      default:                    b = '0;
    endcase
    return b;
  endfunction

  function automatic logic signed [ACC_W-1:0] sext(input logic [WIDTH-1:0] v);
    return signed'({{EXTENDED_BITS{v[WIDTH-1]}}, v});
  endfunction

  // Symmetric saturation keeps -2^(WIDTH-1) out so magnitudes fit WIDTH-1 bits.
  function automatic logic [WIDTH-1:0] sat(input logic signed [ACC_W-1:0] a);
    if (a > SAT_HI) return WIDTH'(MAX_MAG);
    if (a < SAT_LO) return WIDTH'(-MAX_MAG);
    return a[WIDTH-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] clamp_iter(input logic [CNT_W-1:0] n);
    if (n == '0) return CNT_W'(1);
    if (n > CNT_W'(MAX_ITER)) return CNT_W'(MAX_ITER);
    return n;
  endfunction

endpackage

// File: rtl/iter_layer_engine_interm_layer.sv
// Combinational min-sum layer: variable-node sums feeding offset check nodes,
// with the per-pass offset taken from the bias LUT.
module interm_layer
  import iter_layer_engine_pkg::*;
(
  input  logic [WIDTH*N_V-1:0] llrs,
  input  logic [WIDTH*E-1:0]   prev_proc_elem,
  input  logic [INT_SIZE-1:0]  bias_idx,
  output logic [WIDTH*E-1:0]   proc_elem
);

  logic [WIDTH-1:0] v2c [E];
  logic [WIDTH-2:0] mag [E];
  logic [WIDTH-2:0] bias;

  always_comb begin
    logic signed [ACC_W-1:0] sum;
    bias = lut_bias(bias_idx);
    for (int e = 0; e < E; e++) begin
      sum = sext(llrs[EDGE_VAR[e]*WIDTH +: WIDTH]);
      for (int k = 0; k < E; k++) begin
        if (k != e && EDGE_VAR[k] == EDGE_VAR[e])
          sum = sum + sext(prev_proc_elem[k*WIDTH +: WIDTH]);
      end
      v2c[e] = sat(sum);
      mag[e] = v2c[e][WIDTH-1] ? (WIDTH-1)'(-v2c[e]) : v2c[e][WIDTH-2:0];
    end
  end

  always_comb begin
    logic [WIDTH-2:0] min_mag;
    logic [WIDTH-2:0] off;
    logic             neg;
    proc_elem = '0;
    for (int e = 0; e < E; e++) begin
      min_mag = (WIDTH-1)'(MAX_MAG);
      neg     = 1'b0;
      for (int k = 0; k < E; k++) begin
        if (k != e && EDGE_CHK[k] == EDGE_CHK[e]) begin
          if (mag[k] < min_mag) min_mag = mag[k];
          neg = neg ^ v2c[k][WIDTH-1];
        end
      end
      off = (min_mag > bias) ? min_mag - bias : '0;
      proc_elem[e*WIDTH +: WIDTH] = neg ? -{1'b0, off} : {1'b0, off};
    end
  end

endmodule

// File: rtl/iter_layer_engine.sv
// Sequential min-sum decoder: one interm_layer pass per clock, messages fed back
// through msg_reg, result held until downstream accepts it.
// state | meaning
// IDLE  | ready for a codeword (once out of reset)
// RUN   | one layer pass per clock; cnt = passes completed
// HOLD  | result presented until out_ready
module iter_layer_engine
  import iter_layer_engine_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH*N_V-1:0] all_llrs,
  input  logic [CNT_W-1:0]     n_iter,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH*N_V-1:0] llrs_out,
  output logic [WIDTH*E-1:0]   msgs_out,
  output logic [CNT_W-1:0]     iter_done
);

  state_t               state, state_nxt;
  logic                 rst_done, accept, step, last_pass;
  logic [WIDTH*N_V-1:0] llr_reg;
  logic [WIDTH*E-1:0]   msg_reg, proc_elem;
  logic [CNT_W-1:0]     cnt, n_eff, iter_done_reg;

  interm_layer u_layer (
    .llrs           (llr_reg),
    .prev_proc_elem (msg_reg),
    .bias_idx       (INT_SIZE'(cnt)),
    .proc_elem      (proc_elem)
  );

  assign last_pass = (cnt == n_eff - CNT_W'(1));
  assign llrs_out  = llr_reg;
  assign msgs_out  = msg_reg;
  assign iter_done = iter_done_reg;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_done;
        accept   = rst_done && in_valid && !abort;
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        step = !abort;
        if (abort)          state_nxt = IDLE;
        else if (last_pass) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (abort || out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_done      <= 1'b0;
      llr_reg       <= '0;
      msg_reg       <= '0;
      cnt           <= '0;
      n_eff         <= CNT_W'(1);
      iter_done_reg <= '0;
    end else begin
      rst_done <= 1'b1;
      if (accept) begin
        llr_reg <= all_llrs;
        msg_reg <= '0;
        cnt     <= '0;
        n_eff   <= clamp_iter(n_iter);
      end else if (step) begin
        msg_reg <= proc_elem;
        cnt     <= cnt + CNT_W'(1);
        if (last_pass) iter_done_reg <= cnt + CNT_W'(1);
      end else if (state == RUN && abort) begin
        // Aborted mid-run: report only the passes that actually landed in msg_reg.
        iter_done_reg <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_iter_layer_engine.sv
// Randomized self-checking bench for iter_layer_engine against a parity-check-matrix
// min-sum reference model.
module tb_iter_layer_engine;
  import iter_layer_engine_pkg::*;

  localparam int NCHK = 2;
  localparam int H [NCHK][N_V] = '{'{1, 1, 1, 0}, '{0, 1, 1, 1}};
  localparam int BIAS_TAB [MAX_ITER] = '{3, 3, 2, 2, 1, 1, 0, 0};

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 abort = 1'b0;
  logic                 out_ready = 1'b0;
  logic                 in_ready, out_valid;
  logic [WIDTH*N_V-1:0] all_llrs = '0;
  logic [WIDTH*N_V-1:0] llrs_out;
  logic [CNT_W-1:0]     n_iter = '0;
  logic [CNT_W-1:0]     iter_done;
  logic [WIDTH*E-1:0]   msgs_out;
  logic [WIDTH*N_V-1:0] last_llrs = '0;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  iter_layer_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .all_llrs(all_llrs), .n_iter(n_iter), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .llrs_out(llrs_out), .msgs_out(msgs_out), .iter_done(iter_done)
  );

  function automatic int eff(input int n);
    if (n == 0) return 1;
    if (n > MAX_ITER) return MAX_ITER;
    return n;
  endfunction

  function automatic int clip(input int x);
    if (x > MAX_MAG) return MAX_MAG;
    if (x < -MAX_MAG) return -MAX_MAG;
    return x;
  endfunction

  // Offset min-sum on the H matrix; messages flattened row-major over the ones of H.
  function automatic logic [WIDTH*E-1:0] ref_decode(input logic [WIDTH*N_V-1:0] l, input int passes);
    int llr [N_V];
    int c2v [NCHK][N_V];
    int v2c [NCHK][N_V];
    int s, mn, a, neg, e;
    logic [WIDTH*E-1:0] res;
    for (int v = 0; v < N_V; v++) begin
      llr[v] = int'($signed(l[v*WIDTH +: WIDTH]));
      for (int c = 0; c < NCHK; c++) c2v[c][v] = 0;
    end
    for (int p = 0; p < passes; p++) begin
      for (int c = 0; c < NCHK; c++)
        for (int v = 0; v < N_V; v++) begin
          s = llr[v];
          for (int c2 = 0; c2 < NCHK; c2++)
            if (c2 != c && H[c2][v] == 1) s += c2v[c2][v];
          v2c[c][v] = clip(s);
        end
      for (int c = 0; c < NCHK; c++)
        for (int v = 0; v < N_V; v++) begin
          if (H[c][v] == 0) continue;
          mn = 1000;
          neg = 0;
          for (int v2 = 0; v2 < N_V; v2++) begin
            if (v2 == v || H[c][v2] == 0) continue;
            a = (v2c[c][v2] < 0) ? -v2c[c][v2] : v2c[c][v2];
            if (a < mn) mn = a;
            if (v2c[c][v2] < 0) neg ^= 1;
          end
          a = mn - BIAS_TAB[p];
          if (a < 0) a = 0;
          c2v[c][v] = neg ? -a : a;
        end
    end
    res = '0;
    e = 0;
    for (int c = 0; c < NCHK; c++)
      for (int v = 0; v < N_V; v++)
        if (H[c][v] == 1) begin
          res[e*WIDTH +: WIDTH] = WIDTH'(c2v[c][v]);
          e++;
        end
    return res;
  endfunction

  task automatic send(input logic [WIDTH*N_V-1:0] l, input int n, output bit ok);
    int t = 0;
    @(negedge clk);
    all_llrs = l;
    n_iter = CNT_W'(n);
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    all_llrs = WIDTH*N_V'($urandom);
    n_iter = CNT_W'($urandom);
    if (ok) last_llrs = l;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    if (!out_valid) lat = -1;
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++;
    if (msgs_out !== '0 || llrs_out !== '0 || iter_done !== '0)
      $display("FAIL reset_outputs msgs=%h llrs=%h iter=%0d want all 0", msgs_out, llrs_out, iter_done);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_zero_llrs();
    bit ok;
    int lat;
    send('0, 3, ok);
    wait_valid(lat);
    n_total++; if (!ok || lat != 4) $display("FAIL zero_latency got %0d (accepted=%0d) want 4", lat, ok); else n_pass++;
    n_total++; if (msgs_out !== '0) $display("FAIL zero_msgs got %h want 0", msgs_out); else n_pass++;
    n_total++; if (iter_done !== CNT_W'(3)) $display("FAIL zero_iter_done got %0d want 3", iter_done); else n_pass++;
    ack();
  endtask

  task automatic test_random_decode();
    bit ok;
    int lat, n;
    logic [WIDTH*N_V-1:0] l;
    for (int k = 0; k < 4; k++) begin
      l = WIDTH*N_V'($urandom);
      n = (k < 2) ? 5 : int'($urandom_range(1, MAX_ITER));
      send(l, n, ok);
      wait_valid(lat);
      n_total++; if (!ok || lat != n + 1) $display("FAIL rand_latency[%0d] got %0d want %0d", k, lat, n + 1); else n_pass++;
      n_total++; if (msgs_out !== ref_decode(l, n)) $display("FAIL rand_msgs[%0d] got %h want %h", k, msgs_out, ref_decode(l, n)); else n_pass++;
      n_total++; if (llrs_out !== l) $display("FAIL rand_llrs[%0d] got %h want %h", k, llrs_out, l); else n_pass++;
      n_total++; if (iter_done !== CNT_W'(n)) $display("FAIL rand_iter_done[%0d] got %0d want %0d", k, iter_done, n); else n_pass++;
      ack();
    end
  endtask

  task automatic test_clamp();
    bit ok;
    int lat;
    int req [2] = '{0, MAX_ITER + 7};
    logic [WIDTH*N_V-1:0] l;
    for (int k = 0; k < 2; k++) begin
      l = WIDTH*N_V'($urandom);
      send(l, req[k], ok);
      wait_valid(lat);
      n_total++; if (!ok || lat != eff(req[k]) + 1) $display("FAIL clamp_latency n=%0d got %0d want %0d", req[k], lat, eff(req[k]) + 1); else n_pass++;
      n_total++; if (iter_done !== CNT_W'(eff(req[k]))) $display("FAIL clamp_iter_done n=%0d got %0d want %0d", req[k], iter_done, eff(req[k])); else n_pass++;
      n_total++; if (msgs_out !== ref_decode(l, eff(req[k]))) $display("FAIL clamp_msgs n=%0d got %h want %h", req[k], msgs_out, ref_decode(l, eff(req[k]))); else n_pass++;
      ack();
    end
  endtask

  task automatic test_hold_stall();
    bit ok;
    int lat;
    logic [WIDTH*N_V-1:0] l1;
    logic [WIDTH*E-1:0] exp_msgs;
    l1 = WIDTH*N_V'($urandom);
    exp_msgs = ref_decode(l1, 3);
    send(l1, 3, ok);
    wait_valid(lat);
    n_total++; if (!ok || lat != 4) $display("FAIL stall_latency got %0d want 4", lat); else n_pass++;
    in_valid = 1'b1;
    all_llrs = ~l1;
    n_iter = CNT_W'(4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_total++; if (out_valid !== 1'b1) $display("FAIL stall_out_valid[%0d] got %b want 1", i, out_valid); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got %b want 0", i, in_ready); else n_pass++;
      n_total++; if (msgs_out !== exp_msgs) $display("FAIL stall_msgs[%0d] got %h want %h", i, msgs_out, exp_msgs); else n_pass++;
      n_total++; if (llrs_out !== l1) $display("FAIL stall_llrs[%0d] got %h want %h", i, llrs_out, l1); else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL stall_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); else n_pass++;
    n_total++; if (llrs_out !== l1) $display("FAIL stall_second_ignored llrs got %h want %h", llrs_out, l1); else n_pass++;
  endtask

  task automatic test_abort();
    bit ok, seen_valid;
    int lat, n;
    logic [WIDTH*N_V-1:0] l;
    // abort in IDLE blocks acceptance
    @(negedge clk);
    abort = 1'b1;
    in_valid = 1'b1;
    all_llrs = ~last_llrs;
    n_iter = CNT_W'(3);
    @(posedge clk);
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1 || llrs_out !== last_llrs) $display("FAIL abort_idle in_ready=%b llrs=%h want 1/%h", in_ready, llrs_out, last_llrs); else n_pass++;
    abort = 1'b0;
    in_valid = 1'b0;
    // abort after two RUN passes
    l = WIDTH*N_V'($urandom);
    send(l, 6, ok);
    seen_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    if (out_valid) seen_valid = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    n_total++; if (!ok || in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL abort_to_idle in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else n_pass++;
    n_total++; if (iter_done !== CNT_W'(2)) $display("FAIL abort_iter_done got %0d want 2", iter_done); else n_pass++;
    n_total++; if (msgs_out !== ref_decode(l, 2)) $display("FAIL abort_msgs_kept got %h want %h", msgs_out, ref_decode(l, 2)); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    n_total++; if (seen_valid !== 1'b0) $display("FAIL abort_out_valid_rose got 1 want 0"); else n_pass++;
    l = WIDTH*N_V'($urandom);
    n = int'($urandom_range(1, MAX_ITER));
    send(l, n, ok);
    wait_valid(lat);
    n_total++; if (!ok || lat != n + 1) $display("FAIL post_abort_latency got %0d want %0d", lat, n + 1); else n_pass++;
    n_total++; if (msgs_out !== ref_decode(l, n) || iter_done !== CNT_W'(n)) $display("FAIL post_abort_result msgs=%h iter=%0d want %h/%0d", msgs_out, iter_done, ref_decode(l, n), n); else n_pass++;
    ack();
  endtask

  task automatic test_async_rst();
    bit ok;
    int lat;
    logic [WIDTH*N_V-1:0] l;
    l = WIDTH*N_V'($urandom);
    send(l, 7, ok);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL async_rst_handshake in_ready=%b out_valid=%b want 0/0", in_ready, out_valid); else n_pass++;
    n_total++;
    if (msgs_out !== '0 || llrs_out !== '0 || iter_done !== '0)
      $display("FAIL async_rst_outputs msgs=%h llrs=%h iter=%0d want all 0", msgs_out, llrs_out, iter_done);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    l = WIDTH*N_V'($urandom);
    send(l, 4, ok);
    wait_valid(lat);
    n_total++; if (!ok || lat != 5) $display("FAIL post_rst_latency got %0d want 5", lat); else n_pass++;
    n_total++; if (msgs_out !== ref_decode(l, 4) || iter_done !== CNT_W'(4)) $display("FAIL post_rst_result msgs=%h iter=%0d want %h/4", msgs_out, iter_done, ref_decode(l, 4)); else n_pass++;
    ack();
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    logic [WIDTH*N_V-1:0] l;
    l = WIDTH*N_V'($urandom);
    @(negedge clk);
    out_ready = 1'b1;
    all_llrs = l;
    n_iter = CNT_W'(3);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (in_valid && in_ready) begin
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
    end
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    out_ready = 1'b0;
    n_total++; if (first < 0 || second - first != 5) $display("FAIL b2b_interval got %0d want 5", second - first); else n_pass++;
    n_total++; if (msgs_out !== ref_decode(l, 3) || iter_done !== CNT_W'(3)) $display("FAIL b2b_result msgs=%h iter=%0d want %h/3", msgs_out, iter_done, ref_decode(l, 3)); else n_pass++;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout after %0d checks", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_llrs();
    test_random_decode();
    test_clamp();
    test_hold_stall();
    test_abort();
    test_async_rst();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
